// File: rtl/pi_pipeline_mc.sv
// pi_pipeline_mc: multi-channel fixed-point PI controller, 4-stage pipeline.
// Each accepted sample forms err = actual - setpoint, updates that channel's
// stored integral (saturating), and produces
//   out = sat((kp*err + ki*integral) >>> FRAC_BITS).
// Ports:
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_valid, i_channel       sample strobe and channel (>= CHANNELS dropped)
//   i_setpoint, i_actual     signed operands
//   i_kp, i_ki               signed gains, Q(FRAC_BITS)
//   i_hold                   integral not updated for this sample
//   i_clear                  zero all stored integrals
//   o_valid, o_channel       result strobe and channel
//   o_out, o_sat             saturated output, clamp flag
//   o_integral               updated integral of that channel
module pi_pipeline_mc #(
    parameter int unsigned INPUT_WIDTH    = 18,
    parameter int unsigned INTEGRAL_WIDTH = 32,
    parameter int unsigned OUTPUT_WIDTH   = 32,
    parameter int unsigned FRAC_BITS      = 10,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned CH_WIDTH       = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [CH_WIDTH-1:0]       i_channel,
    input  logic [INPUT_WIDTH-1:0]    i_setpoint,
    input  logic [INPUT_WIDTH-1:0]    i_actual,
    input  logic [INPUT_WIDTH-1:0]    i_kp,
    input  logic [INPUT_WIDTH-1:0]    i_ki,
    input  logic                      i_hold,
    input  logic                      i_clear,
    output logic                      o_valid,
    output logic [CH_WIDTH-1:0]       o_channel,
    output logic [OUTPUT_WIDTH-1:0]   o_out,
    output logic [INTEGRAL_WIDTH-1:0] o_integral,
    output logic                      o_sat
);

    localparam int unsigned ERR_W = INPUT_WIDTH + 1;
    localparam int unsigned P_W   = 2 * INPUT_WIDTH + 1;
    localparam int unsigned I_W   = INPUT_WIDTH + INTEGRAL_WIDTH;
    localparam int unsigned S_W   = ((P_W > I_W) ? P_W : I_W) + 1;
    localparam int unsigned A_W   = INTEGRAL_WIDTH + 1;

    localparam logic [INTEGRAL_WIDTH-1:0] INT_POS = {1'b0, {(INTEGRAL_WIDTH-1){1'b1}}};
    localparam logic [INTEGRAL_WIDTH-1:0] INT_NEG = ~INT_POS;
    localparam logic signed [S_W-1:0] OUT_MAX = S_W'({1'b0, {(OUTPUT_WIDTH-1){1'b1}}});
    localparam logic signed [S_W-1:0] OUT_MIN = ~OUT_MAX;

    // Per-channel integral storage
    logic signed [INTEGRAL_WIDTH-1:0] integ_mem [CHANNELS];

    // S0 registers
    logic                             s0_valid;
    logic [CH_WIDTH-1:0]              s0_ch;
    logic signed [ERR_W-1:0]          s0_err;
    logic signed [INPUT_WIDTH-1:0]    s0_kp;
    logic signed [INPUT_WIDTH-1:0]    s0_ki;
    logic                             s0_hold;

    // S1 registers
    logic                             s1_valid;
    logic [CH_WIDTH-1:0]              s1_ch;
    logic signed [ERR_W-1:0]          s1_err;
    logic signed [INPUT_WIDTH-1:0]    s1_kp;
    logic signed [INPUT_WIDTH-1:0]    s1_ki;
    logic signed [INTEGRAL_WIDTH-1:0] s1_int;

    // S2 registers
    logic                             s2_valid;
    logic [CH_WIDTH-1:0]              s2_ch;
    logic signed [P_W-1:0]            s2_p;
    logic signed [I_W-1:0]            s2_i;
    logic signed [INTEGRAL_WIDTH-1:0] s2_int;

    // Combinational stage results
    logic                             ch_ok_c;
    logic signed [ERR_W-1:0]          err_c;
    logic signed [INTEGRAL_WIDTH-1:0] int_rd_c;
    logic signed [A_W-1:0]            int_sum_c;
    logic signed [INTEGRAL_WIDTH-1:0] int_sat_c;
    logic signed [INTEGRAL_WIDTH-1:0] int_upd_c;
    logic signed [P_W-1:0]            p_c;
    logic signed [I_W-1:0]            i_c;
    logic signed [S_W-1:0]            sum_c;
    logic signed [S_W-1:0]            sh_c;
    logic [OUTPUT_WIDTH-1:0]          out_c;
    logic                             sat_c;

    // Datapath for all four stages
    always_comb begin
        ch_ok_c   = 1'b0;
        err_c     = '0;
        int_rd_c  = '0;
        int_sum_c = '0;
        int_sat_c = '0;
        int_upd_c = '0;
        p_c       = '0;
        i_c       = '0;
        sum_c     = '0;
        sh_c      = '0;
        out_c     = '0;
        sat_c     = 1'b0;

        // S0: error is one bit wider than the operands, so it cannot overflow
        ch_ok_c = (32'(i_channel) < CHANNELS);
        err_c   = ERR_W'($signed(i_actual)) - ERR_W'($signed(i_setpoint));

        // S1: read-modify-write of the integral within one cycle. The write lands
        // at the same edge the next sample enters S0->S1, so a back-to-back sample
        // on the same channel reads the freshly written value without a bypass mux.
        int_rd_c  = integ_mem[s0_ch];
        int_sum_c = A_W'(int_rd_c) + A_W'(s0_err);
        if (int_sum_c[A_W-1] != int_sum_c[A_W-2]) begin
            int_sat_c = int_sum_c[A_W-1] ? INT_NEG : INT_POS;
        end else begin
            int_sat_c = int_sum_c[INTEGRAL_WIDTH-1:0];
        end
        int_upd_c = s0_hold ? int_rd_c : int_sat_c;

        // S2: full-precision products
        p_c = P_W'(s1_kp) * P_W'(s1_err);
        i_c = I_W'(s1_ki) * I_W'(s1_int);

        // S3: sum, floor shift, clamp to output range
        sum_c = S_W'(s2_p) + S_W'(s2_i);
        sh_c  = sum_c >>> FRAC_BITS;
        if (sh_c > OUT_MAX) begin
            out_c = OUT_MAX[OUTPUT_WIDTH-1:0];
            sat_c = 1'b1;
        end else if (sh_c < OUT_MIN) begin
            out_c = OUT_MIN[OUTPUT_WIDTH-1:0];
            sat_c = 1'b1;
        end else begin
            out_c = sh_c[OUTPUT_WIDTH-1:0];
        end
    end

    // Integral storage; clear wins over the S1 write-back in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                integ_mem[k] <= '0;
            end
        end else if (i_clear) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                integ_mem[k] <= '0;
            end
        end else if (s0_valid && !s0_hold) begin
            integ_mem[s0_ch] <= int_sat_c;
        end
    end

    // Pipeline registers and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0_valid   <= 1'b0;
            s0_ch      <= '0;
            s0_err     <= '0;
            s0_kp      <= '0;
            s0_ki      <= '0;
            s0_hold    <= 1'b0;
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_err     <= '0;
            s1_kp      <= '0;
            s1_ki      <= '0;
            s1_int     <= '0;
            s2_valid   <= 1'b0;
            s2_ch      <= '0;
            s2_p       <= '0;
            s2_i       <= '0;
            s2_int     <= '0;
            o_valid    <= 1'b0;
            o_channel  <= '0;
            o_out      <= '0;
            o_integral <= '0;
            o_sat      <= 1'b0;
        end else begin
            s0_valid <= i_valid && ch_ok_c;
            s0_ch    <= i_channel;
            s0_err   <= err_c;
            s0_kp    <= $signed(i_kp);
            s0_ki    <= $signed(i_ki);
            s0_hold  <= i_hold;

            s1_valid <= s0_valid;
            s1_ch    <= s0_ch;
            s1_err   <= s0_err;
            s1_kp    <= s0_kp;
            s1_ki    <= s0_ki;
            s1_int   <= int_upd_c;

            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_p     <= p_c;
            s2_i     <= i_c;
            s2_int   <= s1_int;

            o_valid  <= s2_valid;
            // Result fields hold their last value between results
            if (s2_valid) begin
                o_channel  <= s2_ch;
                o_out      <= out_c;
                o_integral <= s2_int;
                o_sat      <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_pi_pipeline_mc.sv
// tb_pi_pipeline_mc: randomized and directed bench for pi_pipeline_mc against
// a sequential arithmetic reference model.
module tb_pi_pipeline_mc;

    localparam int IN_W  = 18;
    localparam int INT_W = 32;
    localparam int OUT_W = 16;
    localparam int FRAC  = 10;
    localparam int NCH   = 5;
    localparam int CH_W  = 3;

    localparam longint INT_MAX_L = 64'sd2147483647;
    localparam longint INT_MIN_L = -64'sd2147483648;
    localparam longint OUT_MAX_L = 64'sd32767;
    localparam longint OUT_MIN_L = -64'sd32768;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [OUT_W-1:0] out;
        logic [INT_W-1:0] integ;
        logic             sat;
    } res_t;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [CH_W-1:0]   i_channel = '0;
    logic [IN_W-1:0]   i_setpoint = '0;
    logic [IN_W-1:0]   i_actual = '0;
    logic [IN_W-1:0]   i_kp = '0;
    logic [IN_W-1:0]   i_ki = '0;
    logic              i_hold = 1'b0;
    logic              i_clear = 1'b0;
    logic              o_valid;
    logic [CH_W-1:0]   o_channel;
    logic [OUT_W-1:0]  o_out;
    logic [INT_W-1:0]  o_integral;
    logic              o_sat;

    int vectors = 0;
    int miscompares = 0;

    longint m_int [NCH];
    res_t   exp_q [$];
    res_t   got_q [$];

    pi_pipeline_mc #(
        .INPUT_WIDTH(IN_W), .INTEGRAL_WIDTH(INT_W), .OUTPUT_WIDTH(OUT_W),
        .FRAC_BITS(FRAC), .CHANNELS(NCH), .CH_WIDTH(CH_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_channel(i_channel),
        .i_setpoint(i_setpoint), .i_actual(i_actual), .i_kp(i_kp), .i_ki(i_ki),
        .i_hold(i_hold), .i_clear(i_clear), .o_valid(o_valid), .o_channel(o_channel),
        .o_out(o_out), .o_integral(o_integral), .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    // Result capture, sampled away from the active edge
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) got_q.push_back({o_channel, o_out, o_integral, o_sat});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: samples processed one at a time in issue order
    function automatic void model(input bit v, input int ch, input int sp, input int act,
                                  input int kp, input int ki, input bit hold, input bit clr);
        longint err, integ, s, o;
        res_t r;
        if (clr) foreach (m_int[k]) m_int[k] = 0;
        if (!v || ch >= NCH) return;
        err   = longint'(act) - longint'(sp);
        integ = m_int[ch];
        if (!hold) begin
            integ = clamp(integ + err, INT_MIN_L, INT_MAX_L);
            m_int[ch] = integ;
        end
        s = longint'(kp) * err + longint'(ki) * integ;
        o = s >>> FRAC;
        r.ch    = CH_W'(ch);
        r.out   = OUT_W'(clamp(o, OUT_MIN_L, OUT_MAX_L));
        r.integ = INT_W'(integ);
        r.sat   = (o > OUT_MAX_L) || (o < OUT_MIN_L);
        exp_q.push_back(r);
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("ch=%0d out=%0d int=%0d sat=%0b", r.ch, $signed(r.out), $signed(r.integ), r.sat);
    endfunction

    task automatic send(input bit v, input int ch, input int sp, input int act,
                        input int kp, input int ki, input bit hold, input bit clr);
        @(posedge i_clk); #1;
        i_valid    = v;
        i_channel  = CH_W'(ch);
        i_setpoint = IN_W'(sp);
        i_actual   = IN_W'(act);
        i_kp       = IN_W'(kp);
        i_ki       = IN_W'(ki);
        i_hold     = hold;
        i_clear    = clr;
        model(v, ch, sp, act, kp, ki, hold, clr);
    endtask

    task automatic idle();
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_hold = 1'b0; i_clear = 1'b0;
    endtask

    // Stop driving and wait (bounded) for all expected results plus slack
    task automatic drain();
        int cyc = 0;
        idle();
        while (got_q.size() < exp_q.size() && cyc < 40) begin
            @(negedge i_clk);
            cyc++;
        end
        repeat (6) @(negedge i_clk);
    endtask

    task automatic test_reset();
        res_t want;
        repeat (2) @(posedge i_clk);
        #1;
        vectors++;
        if ({o_valid, o_channel, o_out, o_integral, o_sat} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got v=%0b %s want all zero", o_valid,
                     fmt({o_channel, o_out, o_integral, o_sat}));
        end
        i_rst = 1'b0;
        send(1, 2, 0, 50, 1024, 0, 0, 0);
        drain();
        want = {3'd2, 16'd50, 32'd50, 1'b0};
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== want) begin
            miscompares++;
            $display("FAIL reset_pre got n=%0d %s want %s", got_q.size(),
                     fmt(got_q.size() > 0 ? got_q[0] : '0), fmt(want));
        end
        got_q.delete(); exp_q.delete();
        // three samples in flight, then reset asserted mid-cycle
        for (int k = 0; k < 3; k++) send(1, 1, 0, 10 + k, 1024, 512, 0, 0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        vectors++;
        if ({o_valid, o_channel, o_out, o_integral, o_sat} !== '0) begin
            miscompares++;
            $display("FAIL reset_async got v=%0b %s want all zero", o_valid,
                     fmt({o_channel, o_out, o_integral, o_sat}));
        end
        exp_q.delete();
        foreach (m_int[k]) m_int[k] = 0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (8) @(negedge i_clk);
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_flush got %0d results want 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_basic();
        res_t want;
        send(1, 0, 100, 300, 1024, 0, 0, 0);
        drain();
        want = {3'd0, 16'd200, 32'd200, 1'b0};
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== want) begin
            miscompares++;
            $display("FAIL basic got n=%0d %s want %s", got_q.size(),
                     fmt(got_q.size() > 0 ? got_q[0] : '0), fmt(want));
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_accum();
        res_t want [3];
        for (int k = 0; k < 3; k++) send(1, 1, 0, 10, 0, 512, 0, 0);
        drain();
        for (int k = 0; k < 3; k++) begin
            want[k] = {3'd1, 16'(5 * (k + 1)), 32'(10 * (k + 1)), 1'b0};
            vectors++;
            if (k >= got_q.size() || got_q[k] !== want[k]) begin
                miscompares++;
                $display("FAIL accum[%0d] got %s want %s", k,
                         fmt(k < got_q.size() ? got_q[k] : '0), fmt(want[k]));
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_interleave();
        res_t w0, w2;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) send(1, 0, 0, 1, 1024, 0, 0, k == 0);
            else            send(1, 2, 1, 0, 1024, 0, 0, 0);
        end
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL interleave_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++;
            if (got_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL interleave[%0d] got %s want %s", k, fmt(got_q[k]), fmt(exp_q[k]));
            end
        end
        w0 = {3'd0, 16'd1, 32'd4, 1'b0};
        w2 = {3'd2, 16'hFFFF, 32'hFFFF_FFFC, 1'b0};
        vectors++;
        if (got_q.size() != 8 || got_q[6] !== w0 || got_q[7] !== w2) begin
            miscompares++;
            $display("FAIL interleave_final got n=%0d want ch0 %s ch2 %s", got_q.size(), fmt(w0), fmt(w2));
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        res_t wp, wn;
        send(1, 3, -131072, 131071, 131071, 0, 0, 1);
        send(1, 3, 131071, -131072, 131071, 0, 0, 0);
        drain();
        wp = {3'd3, 16'h7FFF, 32'd262143, 1'b1};
        wn = {3'd3, 16'h8000, 32'd0, 1'b1};
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== wp || got_q[1] !== wn) begin
            miscompares++;
            $display("FAIL saturation got n=%0d %s / %s want %s / %s", got_q.size(),
                     fmt(got_q.size() > 0 ? got_q[0] : '0), fmt(got_q.size() > 1 ? got_q[1] : '0),
                     fmt(wp), fmt(wn));
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_integral_limits();
        int base;
        // drive ch3 to the positive rail, then +5, hold, and clear-vs-write
        for (int k = 0; k < 8200; k++) send(1, 3, -131072, 131071, 0, 1, 0, k == 0);
        send(1, 3, 0, 5, 0, 0, 0, 0);
        send(1, 3, 7, 0, 0, 0, 1, 0);
        send(1, 3, 0, 5, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0, 0, 1);
        send(1, 3, 0, 3, 0, 0, 0, 0);
        // then down to the negative rail
        for (int k = 0; k < 8200; k++) send(1, 3, 131071, -131072, 0, 1, 0, 0);
        send(1, 5, 0, 100, 1024, 0, 0, 0);
        send(1, 4, 0, 9, 0, 0, 0, 0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL limits_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++;
            if (got_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL limits[%0d] got %s want %s", k, fmt(got_q[k]), fmt(exp_q[k]));
            end
        end
        base = 8200;
        vectors++;
        if (got_q.size() != 16405
            || got_q[base - 1].integ !== 32'h7FFF_FFFF || got_q[base].integ !== 32'h7FFF_FFFF
            || got_q[base + 1].integ !== 32'h7FFF_FFFF || got_q[base + 3].integ !== 32'd3
            || got_q[16403].integ !== 32'h8000_0000 || got_q[16404].ch !== 3'd4) begin
            miscompares++;
            $display("FAIL limits_points got n=%0d want 16405 with +rail, hold, cleared 3, -rail, ch5 dropped",
                     got_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int ch, sp, act, kp, ki;
        bit v, hold, clr;
        for (int k = 0; k < 400; k++) begin
            v    = ($urandom % 4) != 0;
            ch   = int'($urandom_range(0, 7));
            sp   = int'($urandom_range(0, 262143)) - 131072;
            act  = int'($urandom_range(0, 262143)) - 131072;
            kp   = (k % 2 == 0) ? int'($urandom_range(0, 2047)) - 1024 : int'($urandom_range(0, 262143)) - 131072;
            ki   = (k % 3 == 0) ? int'($urandom_range(0, 262143)) - 131072 : int'($urandom_range(0, 63)) - 32;
            hold = ($urandom % 8) == 0;
            clr  = ($urandom % 40) == 0;
            send(v, ch, sp, act, kp, ki, hold, clr);
        end
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++;
            if (got_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL random[%0d] got %s want %s", k, fmt(got_q[k]), fmt(exp_q[k]));
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        foreach (m_int[k]) m_int[k] = 0;
        test_reset();
        test_basic();
        test_accum();
        test_interleave();
        test_saturation();
        test_integral_limits();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
